life_scan_ctrl: RTL
===================

Name: life_scan_ctrl

Overview:
- Master for the life array's serial scan chain; the array's scan port is the responder.
- On request, shifts the whole array out through the chain and captures a CELLS-bit snapshot.
- In read mode it recirculates the bits so the board is unchanged. In load mode it shifts a new pattern in.
- Sits beside the array in Top. Its `run_inhibit` output gates the generation-step trigger while a scan is in progress.

Parameters:
- CELLS, 16, number of cells in the scan chain (array rows*cols).
- SCAN_GAP, 0, idle cycles inserted between consecutive scan pulses (0..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a scan sequence; sampled only in IDLE
- mode  in  1  0 = read/recirculate, 1 = read and load `load_pattern`
- load_pattern  in  CELLS  pattern to write in load mode; sampled on accepted start
- busy  out  1  high from first scan pulse through last scan pulse
- done  out  1  one-cycle pulse after the last scan pulse
- snapshot  out  CELLS  board contents captured by the most recent completed sequence
- snapshot_valid  out  1  set at first done; cleared only by reset
- run_inhibit  out  1  equal to (state != IDLE); gates the array's run input
- scan  out  1  one-cycle shift strobe to the array
- scan_write_val  out  1  bit entering chain head (cell 0) on a scan cycle
- scan_write_enb  out  1  high on every scan cycle
- scan_read_val  in  1  chain tail (cell CELLS-1), combinational from array state

Behaviour:
- Chain contract, fixed for the array: on a clk edge with scan=1, cell k takes cell k-1 and cell 0 takes scan_write_val. scan_read_val always shows the current cell CELLS-1.
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; snapshot=0; snapshot_valid=0; internal shift and pace counters cleared.
  - Reset mid-sequence abandons the scan. The array is left partially rotated; software must reload it.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 → latch mode.
  - Load tx_sr = load_pattern (mode=1) or 0 (mode=0).
  - Clear rx_sr and bit_cnt.
  - Go to SHIFT next cycle.
- SHIFT (scan=1, scan_write_enb=1, busy=1):
  - scan_write_val = scan_read_val if mode=0, else tx_sr[CELLS-1].
  - Same edge: rx_sr <= {rx_sr[CELLS-2:0], scan_read_val}; tx_sr <<= 1; bit_cnt++.
  - If bit_cnt reaches CELLS → DONE.
  - Otherwise → GAP if SCAN_GAP>0, else stay in SHIFT.
- GAP (scan=0, busy=1): wait exactly SCAN_GAP cycles, then → SHIFT.
- DONE (busy=0, scan=0): done=1, snapshot<=rx_sr, snapshot_valid<=1. Next cycle → IDLE.
- Bit ordering:
  - Shift i (0-based) reads original cell CELLS-1-i and writes load_pattern[CELLS-1-i].
  - After CELLS shifts, snapshot[j] = original cell j, and the array cell j = load_pattern[j] (load mode) or the original value (read mode).
- Timing, with the accepted start on cycle 0:
  - Scan pulses on cycles 1 + i*(SCAN_GAP+1), for i = 0..CELLS-1.
  - done on cycle 1 + (CELLS-1)*(SCAN_GAP+1) + 1.
  - Defaults: pulses on cycles 1..16, done on cycle 17, IDLE on cycle 18.
- start outside IDLE is ignored, including in DONE. If start is held high, the next sequence is accepted in IDLE, one cycle after DONE.
- Changes to mode and load_pattern after acceptance have no effect until the next sequence.
- snapshot is stable between done pulses and never shows partial data.

Decomposition:
- Shared package life_pkg:
  - constant CELLS_4X4 = 16
  - scan-controller state encoding (IDLE=0, SHIFT=1, GAP=2, DONE=3)
  - MODE_READ / MODE_LOAD constants
- One natural sub-module: life_scan_pacer, the SCAN_GAP countdown that issues "next pulse" ticks. Everything else lives in life_scan_ctrl.

Test Plan:
- Read mode: behavioural array preloaded 16'hA5C3, start with mode=0 → 16 scan pulses on cycles 1..16; done on cycle 17; snapshot=16'hA5C3; snapshot_valid=1; array still 16'hA5C3.
- Load mode: array 16'hFFFF, load_pattern=16'h0660, mode=1 → snapshot=16'hFFFF; array=16'h0660; scan_write_val sequence = 0,0,0,0,0,1,1,0,0,1,1,0,0,0,0,0.
- SCAN_GAP=2: start at cycle 0 → pulses on cycles 1,4,...,46; busy high cycles 1..46; done on cycle 47; run_inhibit high cycles 1..47.
- start pulsed on cycles 5 and 17 during a default sequence → both ignored. Exactly 16 pulses, one done. A second start on cycle 18 begins a new sequence (first pulse on cycle 19).
- Reset asserted asynchronously mid-cycle after the 5th pulse → scan, busy, done, run_inhibit, snapshot and snapshot_valid go to 0 immediately. After release, state is IDLE and no pulse occurs without start.
- start held high continuously for 40 cycles with mode=0 → done on cycles 17 and 35. Second snapshot equals the first, and the board is unchanged.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the life array scan controller.
//   CELLS_4X4     default chain length (4x4 board)
//   GAP_W         width of the inter-pulse gap counter (SCAN_GAP 0..255)
//   scan_state_e  scan controller state encoding
//   MODE_READ/MODE_LOAD  values of the mode input
package life_pkg;

  localparam int CELLS_4X4 = 16;
  localparam int GAP_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  // Counter reload for a gap of `gap` idle cycles; the pacer counts down to
  // zero, so a gap of N loads N-1. A zero gap never arms the pacer.
  function automatic logic [GAP_W-1:0] gap_reload(input int gap);
    return (gap > 0) ? GAP_W'(gap - 1) : '0;
  endfunction

endpackage

// File: rtl/life_scan_pacer.sv
// life_scan_pacer: counts the idle cycles between two scan pulses.
//   clk, reset  clock, async active-low reset
//   arm         pulse on a scan cycle that will be followed by a gap
//   active      high while the controller sits in the gap state
//   tick        high on the last gap cycle; the next cycle is a scan pulse
module life_scan_pacer
  import life_pkg::*;
#(
  parameter int SCAN_GAP = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic active,
  output logic tick
);

  localparam logic [GAP_W-1:0] RELOAD = gap_reload(SCAN_GAP);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cnt <= '0;
    else if (arm)                   cnt <= RELOAD;
    else if (active && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tick = active && (cnt == '0);

endmodule

// File: rtl/life_scan_ctrl.sv
// life_scan_ctrl: scan-chain master for the life array.
// Shifts the whole chain once per request, capturing a CELLS-bit snapshot.
// Read mode feeds the tail back into the head so the board is unchanged;
// load mode feeds load_pattern in MSB first.
//   clk, reset        clock, async active-low reset
//   start             request a scan sequence (honoured only in IDLE)
//   mode              0 = read/recirculate, 1 = load load_pattern
//   load_pattern      pattern written in load mode, latched on start
//   busy              high from first through last scan pulse
//   done              one-cycle pulse after the last scan pulse
//   snapshot          board captured by the last completed sequence
//   snapshot_valid    set by the first completed sequence
//   run_inhibit       high whenever a sequence is in progress
//   scan              shift strobe to the array
//   scan_write_val    bit entering cell 0 on a scan cycle
//   scan_write_enb    write enable, high on every scan cycle
//   scan_read_val     current value of cell CELLS-1
module life_scan_ctrl
  import life_pkg::*;
#(
  parameter int CELLS    = CELLS_4X4,
  parameter int SCAN_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CELLS-1:0] load_pattern,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] snapshot,
  output logic             snapshot_valid,
  output logic             run_inhibit,
  output logic             scan,
  output logic             scan_write_val,
  output logic             scan_write_enb,
  input  logic             scan_read_val
);

  localparam int               CNT_W = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CELLS);
  localparam bit               HAS_GAP = (SCAN_GAP > 0);

  scan_state_e      state, state_nxt;
  logic             mode_q;
  logic [CELLS-1:0] tx_sr, rx_sr;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_inc;
  logic             last_shift;
  logic             pace_arm, pace_tick;

  assign bit_cnt_inc = bit_cnt + 1'b1;
  assign last_shift  = (bit_cnt_inc == LAST);
  assign pace_arm    = (state == ST_SHIFT) && !last_shift && HAS_GAP;

  life_scan_pacer #(.SCAN_GAP(SCAN_GAP)) u_pacer (
    .clk    (clk),
    .reset  (reset),
    .arm    (pace_arm),
    .active (state == ST_GAP),
    .tick   (pace_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    scan           = 1'b0;
    scan_write_enb = 1'b0;
    scan_write_val = 1'b0;
    run_inhibit    = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy           = 1'b1;
        scan           = 1'b1;
        scan_write_enb = 1'b1;
        // Read mode recirculates the tail so the board survives the scan.
        scan_write_val = (mode_q == MODE_LOAD) ? tx_sr[CELLS-1] : scan_read_val;
        if (last_shift)   state_nxt = ST_DONE;
        else if (HAS_GAP) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
        if (pace_tick) state_nxt = ST_SHIFT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. The tail is read first, so shifting rx_sr left leaves cell j
  // in bit j after the last pulse; tx_sr is sent MSB first for the same
  // reason. snapshot only moves in DONE, so it never shows partial data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q         <= MODE_READ;
      tx_sr          <= '0;
      rx_sr          <= '0;
      bit_cnt        <= '0;
      snapshot       <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            tx_sr   <= (mode == MODE_LOAD) ? load_pattern : '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          rx_sr   <= {rx_sr[CELLS-2:0], scan_read_val};
          tx_sr   <= tx_sr << 1;
          bit_cnt <= bit_cnt_inc;
        end
        ST_DONE: begin
          snapshot       <= rx_sr;
          snapshot_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
